// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states and the default datapath width.
package mips_mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: yields the magnitude of a signed
// operand, or re-applies a sign to an unsigned result.
module mdu_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? ('0 - value) : value;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one result
// bit per cycle, XLEN+2 cycles from accepted start to the done pulse.
module mdu_iterative
    import mips_mdu_pkg::*;
#(
    parameter int unsigned XLEN  = MDU_XLEN,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            abort,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    mdu_state_t      state, state_nxt;
    mdu_op_t         op_in, op_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            sa, sb;
    logic [XLEN-1:0] acc_hi, acc_lo;
    logic [XLEN-1:0] hi_q, lo_q;

    logic            start_ok;
    logic            in_signed, rs_neg, rt_neg;
    logic [XLEN-1:0] rs_mag, rt_mag;
    logic [2*XLEN-1:0] prod_res;
    logic [XLEN-1:0] quo_res, rem_res;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    assign op_in     = mdu_op_t'(op);
    assign in_signed = op_is_signed(op_in);
    assign rs_neg    = in_signed & rs_val[XLEN-1];
    assign rt_neg    = in_signed & rt_val[XLEN-1];
    assign start_ok  = (state == IDLE) && start && !abort;

    mdu_sign_fix #(.W(XLEN)) u_rs_fix (.value(rs_val), .negate(rs_neg), .result(rs_mag));
    mdu_sign_fix #(.W(XLEN)) u_rt_fix (.value(rt_val), .negate(rt_neg), .result(rt_mag));

    mdu_sign_fix #(.W(2*XLEN)) u_prod_fix (
        .value({acc_hi, acc_lo}), .negate(sa ^ sb), .result(prod_res)
    );
    mdu_sign_fix #(.W(XLEN)) u_quo_fix (.value(acc_lo), .negate(sa ^ sb), .result(quo_res));
    mdu_sign_fix #(.W(XLEN)) u_rem_fix (.value(acc_hi), .negate(sa), .result(rem_res));

    // Multiply: acc_lo holds the multiplier and shifts right as product bits fill in.
    // Divide:   acc_lo holds the dividend shifting left while quotient bits enter at bit 0.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = CALC;
            CALC:    if (abort) state_nxt = IDLE;
                     else if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:     state_nxt = abort ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= MDU_MULT;
            cnt    <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mthi) hi_q <= wdata;
                    if (mtlo) lo_q <= wdata;
                    if (start_ok) begin
                        op_q   <= op_in;
                        cnt    <= '0;
                        a_mag  <= rs_mag;
                        b_mag  <= rt_mag;
                        sa     <= rs_neg;
                        sb     <= rt_neg;
                        acc_hi <= '0;
                        acc_lo <= op_is_div(op_in) ? rs_mag : rt_mag;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_is_div(op_q)) begin
                        if (!div_diff[XLEN]) begin
                            acc_hi <= div_diff[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    if (!abort) begin
                        if (op_is_div(op_q)) begin
                            // Divide by zero leaves the dividend magnitude as remainder, so
                            // re-signing it restores rs_val; only the quotient is forced.
                            lo_q <= (b_mag == '0) ? '1 : quo_res;
                            hi_q <= rem_res;
                        end else begin
                            {hi_q, lo_q} <= prod_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

endmodule
